// File: rtl/bcd_conv_arb_pkg.sv
// Shared definitions for the arbitrated binary-to-BCD display converter:
// FSM state encoding, sign-code constants and elaboration helpers.
package bcd_conv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SGN_NEG   = 4'b1010;
  localparam logic [3:0] SGN_BLANK = 4'b1111;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic longint pow10(input int d);
    longint p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_conv_arb_bin2bcd.sv
// Combinational double-dabble converter with optional two's complement
// magnitude/sign split.
module bcd_conv_arb_bin2bcd
  import bcd_conv_arb_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int DIGITS  = 2,
  parameter int ABS_VAL = 1
) (
  input  logic [WIDTH-1:0]    op,
  output logic [DIGITS*4-1:0] bcd,
  output logic [3:0]          sgn
);

  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly 2^(WIDTH-1); no extra bit is needed.
  localparam longint MAX_MAG = (ABS_VAL != 0) ? (longint'(1) << (WIDTH - 1))
                                              : ((longint'(1) << WIDTH) - 1);

  if (pow10(DIGITS) <= MAX_MAG) begin : g_digits_chk
    $error("bcd_conv_arb_bin2bcd: DIGITS too small for WIDTH");
  end

  logic                  neg;
  logic [WIDTH-1:0]      mag;
  logic [DIGITS*4-1:0]   acc;

  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    neg = (ABS_VAL != 0) && op[WIDTH-1];
    mag = neg ? (WIDTH'(0) - op) : op;
    sgn = neg ? SGN_NEG : SGN_BLANK;
    acc = '0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[d*4 +: 4] >= 4'd5) acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc = {acc[DIGITS*4-2:0], mag[b]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/bcd_conv_arb.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ
// requesters; two cycles per conversion, back-to-back grants from DONE.
module bcd_conv_arb
  import bcd_conv_arb_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int DIGITS  = 2,
  parameter int ABS_VAL = 1,
  parameter int N_REQ   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH-1:0]    bin_i,
  output logic [N_REQ-1:0]          ack,
  output logic [DIGITS*4-1:0]       bcd_o,
  output logic [3:0]                sgn_o,
  output logic [clog2(N_REQ)-1:0]   gnt_id,
  output logic                      busy
);

  localparam int ID_W = clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_chk
    $error("bcd_conv_arb: N_REQ must be in 2..8");
  end

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    op_q;
  logic [ID_W-1:0]     ptr;
  logic [WIDTH-1:0]    ops [N_REQ];
  logic [N_REQ-1:0]    cand;
  logic [ID_W-1:0]     base, win, gnt_inc;
  logic                found, load;
  int                  idx;
  logic [DIGITS*4-1:0] conv_bcd;
  logic [3:0]          conv_sgn;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) ops[k] = bin_i[k*WIDTH +: WIDTH];
  end

  always_comb begin
    gnt_inc = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
  end

  // In DONE the pointer is being advanced this very cycle, so the search
  // already starts at gnt_id+1 and the current owner's stale req is masked.
  always_comb begin
    base  = (state == DONE) ? gnt_inc : ptr;
    cand  = req;
    if (state == DONE) cand[gnt_id] = 1'b0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(base) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    load = found && (state == IDLE || state == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CONV;
      CONV:    state_nxt = DONE;
      DONE:    state_nxt = found ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    ack  = '0;
    if (state == DONE) ack[gnt_id] = 1'b1;
  end

  // NOTE: op_q is a plain register, not storage array, so it is reset along
  // with the rest of the datapath to keep post-reset state deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      gnt_id <= '0;
      ptr    <= '0;
      bcd_o  <= '0;
      sgn_o  <= SGN_BLANK;
    end else begin
      if (load) begin
        op_q   <= ops[win];
        gnt_id <= win;
      end
      if (state == CONV) begin
        bcd_o <= conv_bcd;
        sgn_o <= conv_sgn;
      end
      if (state == DONE) ptr <= gnt_inc;
    end
  end

  bcd_conv_arb_bin2bcd #(
    .WIDTH   (WIDTH),
    .DIGITS  (DIGITS),
    .ABS_VAL (ABS_VAL)
  ) u_bin2bcd (
    .op  (op_q),
    .bcd (conv_bcd),
    .sgn (conv_sgn)
  );

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Scoreboard bench for bcd_conv_arb: expected acks are queued when requests
// are driven and compared when the DUT pulses ack.
module tb_bcd_conv_arb;

  localparam int WIDTH  = 6;
  localparam int DIGITS = 2;
  localparam int N_REQ  = 4;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] bin_i;
  logic [N_REQ-1:0]       ack;
  logic [DIGITS*4-1:0]    bcd_o;
  logic [3:0]             sgn_o;
  logic [1:0]             gnt_id;
  logic                   busy;

  bcd_conv_arb #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .ABS_VAL(1), .N_REQ(N_REQ)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .bin_i(bin_i), .ack(ack),
    .bcd_o(bcd_o), .sgn_o(sgn_o), .gnt_id(gnt_id), .busy(busy)
  );

  typedef struct {
    int          idx;
    logic [7:0]  bcd;
    logic [3:0]  sgn;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference conversion by plain arithmetic, independent of double-dabble.
  function automatic void model(input logic [5:0] op, output logic [7:0] bcd,
                                output logic [3:0] sgn);
    int v;
    v = int'(op);
    if (op[5]) begin
      v   = 64 - v;
      sgn = 4'hA;
    end else begin
      sgn = 4'hF;
    end
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic expect_ack(input int k, input logic [5:0] op, input int at_cyc);
    exp_t e;
    e.idx = k;
    model(op, e.bcd, e.sgn);
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic set_op(input int k, input logic [5:0] v);
    bin_i[k*WIDTH +: WIDTH] = v;
  endtask

  // Advance one cycle; a requester drops req the cycle after its ack.
  task automatic step();
    logic [N_REQ-1:0] a;
    a = ack;
    @(posedge clk);
    #1;
    req = req & ~a;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"},  32'(ack),    32'h0);
    check({tag, "_bcd"},  32'(bcd_o),  32'h0);
    check({tag, "_sgn"},  32'(sgn_o),  32'hF);
    check({tag, "_gnt"},  32'(gnt_id), 32'h0);
    check({tag, "_busy"}, 32'(busy),   32'h0);
  endtask

  always @(negedge clk) begin
    if (ack !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_vec",   32'(ack),   32'(1 << e.idx));
        check("ack_bcd",   32'(bcd_o), 32'(e.bcd));
        check("ack_sgn",   32'(sgn_o), 32'(e.sgn));
        check("ack_cycle", 32'(cyc),   32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [5:0] v;
    int k;

    // Reset with all four requests already pending.
    rst = 1'b1;
    req = '0;
    bin_i = '0;
    set_op(0, 6'd31);
    set_op(1, 6'd9);
    set_op(2, 6'b111011);
    set_op(3, 6'b100000);
    req = 4'b1111;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_vals("reset");

    // All four simultaneous: served 0,1,2,3 every two cycles.
    rst = 1'b0;
    c = cyc;
    expect_ack(0, 6'd31,     c + 2);
    expect_ack(1, 6'd9,      c + 4);
    expect_ack(2, 6'b111011, c + 6);
    expect_ack(3, 6'b100000, c + 8);
    repeat (10) step();
    check("rr4_idle", 32'(busy), 32'h0);

    // Single request, busy profile.
    set_op(0, 6'd31);
    req = 4'b0001;
    c = cyc;
    expect_ack(0, 6'd31, c + 2);
    check("single_busy_c0", 32'(busy), 32'h0);
    step();
    check("single_busy_c1", 32'(busy), 32'h1);
    step();
    check("single_busy_c2", 32'(busy), 32'h1);
    step();
    check("single_busy_c3", 32'(busy), 32'h0);

    // Negative operand on requester 2; leaves pointer at 3.
    set_op(2, 6'b111011);
    req = 4'b0100;
    c = cyc;
    expect_ack(2, 6'b111011, c + 2);
    repeat (3) step();

    // Wrap fairness: pointer 3 with req0 and req3, most-negative on 3.
    set_op(0, 6'd27);
    set_op(3, 6'b100000);
    req = 4'b1001;
    c = cyc;
    expect_ack(3, 6'b100000, c + 2);
    expect_ack(0, 6'd27,     c + 4);
    repeat (6) step();

    // Request withdrawn during CONV: ack still pulses, then IDLE.
    set_op(1, 6'd45);
    req = 4'b0010;
    c = cyc;
    expect_ack(1, 6'd45, c + 2);
    step();
    check("withdraw_gnt", 32'(gnt_id), 32'h1);
    req = 4'b0000;
    step();
    step();
    check("withdraw_idle", 32'(busy), 32'h0);

    // Reset during CONV: no ack for that grant, outputs back to reset values.
    set_op(2, 6'd17);
    req = 4'b0100;
    step();
    check("rst_mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    req = 4'b0000;
    step();
    check_reset_vals("rst_mid");
    rst = 1'b0;
    repeat (3) step();

    // Pointer cleared by reset: 0 wins over 3.
    set_op(0, 6'd63);
    set_op(3, 6'd50);
    req = 4'b1001;
    c = cyc;
    expect_ack(0, 6'd63, c + 2);
    expect_ack(3, 6'd50, c + 4);
    repeat (6) step();

    // Random single conversions.
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, N_REQ - 1);
      v = 6'($urandom_range(0, 63));
      set_op(k, v);
      req = 4'(1 << k);
      c = cyc;
      expect_ack(k, v, c + 2);
      repeat (3) step();
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
